// File: rtl/ccs_pkg.sv
// Shared types and constants for the CCS (Count, Compare, Skip) executor.
package ccs_pkg;

    localparam int CCS_WORD_W  = 16;
    localparam int CCS_ADDR_W  = 12;
    localparam int CCS_TMO_CYC = 15;

    // Operand class, encoded as it appears on the cls output
    typedef enum logic [1:0] {
        CLS_POS = 2'd0,
        CLS_PZ  = 2'd1,
        CLS_NEG = 2'd2,
        CLS_NZ  = 2'd3
    } cls_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EVAL  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] SKIP_POS = 3'd1;
    localparam logic [2:0] SKIP_PZ  = 3'd2;
    localparam logic [2:0] SKIP_NEG = 3'd3;
    localparam logic [2:0] SKIP_NZ  = 3'd4;

endpackage

// File: rtl/ccs_exec_if.sv
// Sequencer, memory-read and write-port signals of the CCS executor.
// Handshake: mem_rd_req is held with a stable mem_rd_addr until the first cycle mem_rd_ack=1,
// which may be the cycle mem_rd_req rises; mem_rd_data is sampled only in that cycle.
interface ccs_exec_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] operand_addr;
    logic [ADDR_W-1:0] pc_in;
    logic              busy;
    logic              done;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic [WORD_W-1:0] mem_rd_data;
    logic              a_we;
    logic [WORD_W-1:0] a_wdata;
    logic              pc_we;
    logic [ADDR_W-1:0] pc_wdata;
    logic [1:0]        cls;
    logic              err;

    // Sequencer / memory / register-file side
    modport master (
        output start, operand_addr, pc_in, mem_rd_ack, mem_rd_data,
        input  busy, done, mem_rd_req, mem_rd_addr, a_we, a_wdata,
        input  pc_we, pc_wdata, cls, err
    );

    // Executor side
    modport slave (
        input  start, operand_addr, pc_in, mem_rd_ack, mem_rd_data,
        output busy, done, mem_rd_req, mem_rd_addr, a_we, a_wdata,
        output pc_we, pc_wdata, cls, err
    );
endinterface

// File: rtl/ccs_dabs.sv
// Combinational CCS classifier: ones' complement word -> {class, diminished abs, skip}.
module ccs_dabs
    import ccs_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] word,
    output cls_t              cls,
    output logic [WORD_W-1:0] dabs,
    output logic [2:0]        skip
);

    logic is_zero;
    logic is_ones;

    assign is_zero = ~|word;
    assign is_ones = &word;

    // -0 maps to a +0 result; the two zero classes never reach the subtractors
    always_comb begin
        cls  = CLS_POS;
        dabs = '0;
        skip = SKIP_POS;
        if (is_zero) begin
            cls  = CLS_PZ;
            skip = SKIP_PZ;
        end else if (is_ones) begin
            cls  = CLS_NZ;
            skip = SKIP_NZ;
        end else if (!word[WORD_W-1]) begin
            cls  = CLS_POS;
            dabs = word - 1'b1;
            skip = SKIP_POS;
        end else begin
            cls  = CLS_NEG;
            dabs = ~word - 1'b1;
            skip = SKIP_NEG;
        end
    end

endmodule

// File: rtl/ccs_exec.sv
// Multi-cycle CCS executor: read operand, classify, write DABS to A and skipped PC.
// Build option CCS_TIMEOUT_EN adds a READ timeout that aborts with err+done.
module ccs_exec
    import ccs_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TMO_CYC = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    ccs_exec_if.slave                      bus,
    output state_t                         dbg_state,
    output logic [$clog2(TMO_CYC+1)-1:0]   dbg_tmo_cnt
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    state_t            state;
    state_t            state_n;
    logic              start_ok;
    logic              tmo_hit;
    logic              err_q;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [WORD_W-1:0] data_q;
    cls_t              cls_q;
    logic [WORD_W-1:0] a_q;
    logic [ADDR_W-1:0] pc_out_q;

    cls_t              ev_cls;
    logic [WORD_W-1:0] ev_dabs;
    logic [2:0]        ev_skip;

    logic              busy_c;
    logic              done_c;
    logic              req_c;
    logic              wr_c;

`ifdef CCS_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_cnt;

    assign tmo_hit = (state == READ) && !bus.mem_rd_ack
                     && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    // The abort pulse is emitted from IDLE, so starts are held off for that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state != READ) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign dbg_tmo_cnt = tmo_cnt;
`else
    assign tmo_hit     = 1'b0;
    assign err_q       = 1'b0;
    assign dbg_tmo_cnt = '0;
`endif

    assign start_ok = bus.start && !err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start_ok) state_n = READ;
            READ: begin
                if (bus.mem_rd_ack) begin
                    state_n = EVAL;
                end else if (tmo_hit) begin
                    state_n = IDLE;
                end
            end
            EVAL:  state_n = WRITE;
            WRITE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != IDLE) || err_q;
        req_c  = (state == READ);
        wr_c   = (state == WRITE);
        done_c = wr_c || err_q;
    end

    ccs_dabs #(.WORD_W(WORD_W)) u_dabs (
        .word (data_q),
        .cls  (ev_cls),
        .dabs (ev_dabs),
        .skip (ev_skip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            pc_q     <= '0;
            data_q   <= '0;
            cls_q    <= CLS_POS;
            a_q      <= '0;
            pc_out_q <= '0;
        end else begin
            if (state == IDLE && start_ok) begin
                addr_q <= bus.operand_addr;
                pc_q   <= bus.pc_in;
            end
            if (state == READ && bus.mem_rd_ack) begin
                data_q <= bus.mem_rd_data;
            end
            // Results hold after WRITE so cls keeps reporting the last operand
            if (state == EVAL) begin
                cls_q    <= ev_cls;
                a_q      <= ev_dabs;
                pc_out_q <= pc_q + ADDR_W'(ev_skip);
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.mem_rd_req  = req_c;
    assign bus.mem_rd_addr = addr_q;
    assign bus.a_we        = wr_c;
    assign bus.a_wdata     = a_q;
    assign bus.pc_we       = wr_c;
    assign bus.pc_wdata    = pc_out_q;
    assign bus.cls         = cls_q;
    assign bus.err         = err_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_ccs_exec.sv
// Self-checking bench for ccs_exec: randomized operations against a behavioural model.
module tb_ccs_exec;
    import ccs_pkg::*;

    localparam int TMO = 15;

    logic       clk;
    logic       rst;
    state_t     dbg_state;
    logic [3:0] dbg_tmo_cnt;

    int n_chk = 0;
    int n_err = 0;

    ccs_exec_if #(.WORD_W(16), .ADDR_W(12)) bus ();

    ccs_exec #(.WORD_W(16), .ADDR_W(12), .TMO_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state   (dbg_state),
        .dbg_tmo_cnt (dbg_tmo_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ones' complement meaning of the word, straight from the class rules
    function automatic void ref_ccs(input logic [15:0] w, output logic [15:0] a,
                                    output int skip, output int c);
        int mag;
        if (w == 16'h0000) begin
            c = 1; a = 16'h0; skip = 2;
        end else if (w == 16'hFFFF) begin
            c = 3; a = 16'h0; skip = 4;
        end else if (w < 16'h8000) begin
            mag = int'(w);
            c = 0; a = 16'(mag - 1); skip = 1;
        end else begin
            mag = 65535 - int'(w);
            c = 2; a = 16'(mag - 1); skip = 3;
        end
    endfunction

    int          cyc = 0;
    bit          m_busy, m_req;
    int          m_done_at, m_err_at, m_req_start;
    logic [11:0] m_addr, m_pc;
    logic [15:0] res_a, exp_a;
    logic [11:0] res_pc, exp_pc;
    logic [1:0]  res_cls, exp_cls;

    task automatic model_reset();
        m_busy = 0; m_req = 0; m_done_at = -1; m_err_at = -1; m_req_start = 0;
        exp_a = '0; exp_pc = '0; exp_cls = '0;
    endtask

    // Compare process: outputs are sampled mid-cycle, then the model absorbs this cycle's inputs
    always @(negedge clk) begin
        logic [15:0] ra;
        int rs, rc;
        bit e_req, e_we, e_err, e_busy;
        cyc++;
        if (rst) begin
            model_reset();
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_req", bus.mem_rd_req, 0);
            chk("rst_a_we", bus.a_we, 0);
            chk("rst_pc_we", bus.pc_we, 0);
            chk("rst_err", bus.err, 0);
            chk("rst_cls", bus.cls, 0);
            chk("rst_a_wdata", bus.a_wdata, 0);
            chk("rst_pc_wdata", bus.pc_wdata, 0);
            chk("rst_rd_addr", bus.mem_rd_addr, 0);
        end else begin
            e_req  = m_req;
            e_we   = (cyc == m_done_at);
            e_err  = (cyc == m_err_at);
            e_busy = m_busy;
            if (e_we) begin
                exp_a = res_a; exp_pc = res_pc; exp_cls = res_cls;
            end
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_we || e_err);
            chk("mem_rd_req", bus.mem_rd_req, e_req);
            chk("a_we", bus.a_we, e_we);
            chk("pc_we", bus.pc_we, e_we);
            chk("err", bus.err, e_err);
            chk("cls", bus.cls, exp_cls);
            chk("a_wdata", bus.a_wdata, exp_a);
            chk("pc_wdata", bus.pc_wdata, exp_pc);
            if (e_req) chk("mem_rd_addr", bus.mem_rd_addr, m_addr);

            if (e_we || e_err) begin
                m_busy = 0;
            end else if (m_req) begin
                if (bus.mem_rd_ack) begin
                    ref_ccs(bus.mem_rd_data, ra, rs, rc);
                    res_a     = ra;
                    res_pc    = 12'((int'(m_pc) + rs) % 4096);
                    res_cls   = 2'(rc);
                    m_req     = 0;
                    m_done_at = cyc + 2;
`ifdef CCS_TIMEOUT_EN
                end else if (cyc - m_req_start == TMO - 1) begin
                    m_req    = 0;
                    m_err_at = cyc + 1;
`endif
                end
            end
            if (!e_busy && bus.start) begin
                m_busy = 1; m_req = 1; m_req_start = cyc + 1;
                m_addr = bus.operand_addr; m_pc = bus.pc_in;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One operation: start, ack after dly READ cycles, optional extra starts, then wait for done
    task automatic do_op(input logic [11:0] addr, input logic [11:0] pc, input logic [15:0] data,
                         input int dly, input bit dup, input bit late,
                         output bit got, output logic [15:0] a, output logic [11:0] p,
                         output logic [1:0] c);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.operand_addr = addr; bus.pc_in = pc;
        bus.mem_rd_ack = 1'b0;
        @(posedge clk); #1;
        bus.operand_addr = 12'($urandom); bus.pc_in = 12'($urandom);
        for (int i = 0; i <= dly; i++) begin
            bus.start = dup && (i == 0);
            if (i == dly) begin
                bus.mem_rd_ack = 1'b1; bus.mem_rd_data = data;
            end else begin
                bus.mem_rd_ack = 1'b0; bus.mem_rd_data = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        got = 0; a = '0; p = '0; c = '0;
        for (int j = 0; j < 8 && !got; j++) begin
            bus.start = late;
            bus.mem_rd_ack = 1'($urandom_range(0, 1));
            bus.mem_rd_data = 16'($urandom);
            @(negedge clk);
            if (bus.done) begin
                got = 1; a = bus.a_wdata; p = bus.pc_wdata; c = bus.cls;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.mem_rd_ack = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [11:0] addr, input logic [11:0] pc,
                           input logic [15:0] data, input int dly, input bit dup,
                           input logic [15:0] ea, input logic [11:0] ep, input logic [1:0] ec);
        bit got;
        logic [15:0] a;
        logic [11:0] p;
        logic [1:0]  c;
        do_op(addr, pc, data, dly, dup, 1'b0, got, a, p, c);
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_a"}, a, ea);
        chk({tag, "_pc"}, p, ep);
        chk({tag, "_cls"}, c, ec);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ma, d;
        int ms, mc, sel;
        bit got;
        logic [15:0] a;
        logic [11:0] p;
        logic [1:0]  c;

        rst = 1'b1;
        bus.start = 1'b0; bus.operand_addr = '0; bus.pc_in = '0;
        bus.mem_rd_ack = 1'b0; bus.mem_rd_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model to hand-computed values
        ref_ccs(16'hFFFA, ma, ms, mc);
        chk("model_neg5_a", ma, 16'h0004);
        chk("model_neg5_skip", ms, 3);
        ref_ccs(16'h8000, ma, ms, mc);
        chk("model_most_neg_a", ma, 16'h7FFE);

        run_dir("t1_pos5",    12'h010, 12'h100, 16'h0005, 2, 0, 16'h0004, 12'h101, 2'd0);
        run_dir("t2_pzero",   12'h011, 12'h100, 16'h0000, 1, 0, 16'h0000, 12'h102, 2'd1);
        run_dir("t2_nzero",   12'h012, 12'h100, 16'hFFFF, 0, 0, 16'h0000, 12'h104, 2'd3);
        run_dir("t3_neg5",    12'h013, 12'h200, 16'hFFFA, 3, 0, 16'h0004, 12'h203, 2'd2);
        run_dir("t3_mostneg", 12'h014, 12'h200, 16'h8000, 1, 0, 16'h7FFE, 12'h203, 2'd2);
        run_dir("t4_pcwrap",  12'h015, 12'hFFF, 16'h0001, 0, 0, 16'h0000, 12'h000, 2'd0);
        run_dir("t4_dupstart",12'h016, 12'h300, 16'h7FFF, 2, 1, 16'h7FFE, 12'h301, 2'd0);

        // Reset during READ
        @(posedge clk); #1;
        bus.start = 1'b1; bus.operand_addr = 12'h020; bus.pc_in = 12'h400;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("t5_req_before_rst", bus.mem_rd_req, 1);
        rst = 1'b1;
        #1;
        chk("t5_req_dropped", bus.mem_rd_req, 0);
        chk("t5_busy_dropped", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_dir("t5_after_rst", 12'h021, 12'h400, 16'h0010, 1, 0, 16'h000F, 12'h401, 2'd0);

        // Randomized operations with spurious idle acks and ignored extra starts
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'h0001;
                3: d = 16'h8000;
                4: d = 16'hFFFE;
                5: d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            do_op(12'($urandom), 12'($urandom), d, $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got, a, p, c);
            chk("rand_done_seen", got, 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.mem_rd_ack = 1'($urandom_range(0, 1));
                bus.mem_rd_data = 16'($urandom);
                @(posedge clk); #1;
            end
            bus.mem_rd_ack = 1'b0;
        end

`ifdef CCS_TIMEOUT_EN
        begin
            int rise, errat;
            bit seen, wr, dn;
            rise = -1; errat = -1; seen = 0; wr = 0; dn = 0;
            @(posedge clk); #1;
            bus.start = 1'b1; bus.operand_addr = 12'h030; bus.pc_in = 12'h500;
            @(posedge clk); #1;
            bus.start = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (bus.mem_rd_req && rise < 0) rise = i;
                if (bus.err) begin
                    seen = 1; errat = i; dn = bus.done; wr = bus.a_we || bus.pc_we;
                end
            end
            chk("t6_err_seen", seen, 1);
            chk("t6_err_latency", 32'(errat - rise), 32'(TMO));
            chk("t6_done_with_err", dn, 1);
            chk("t6_no_write", wr, 0);
            @(posedge clk); #1;
            run_dir("t6_after_tmo", 12'h031, 12'h500, 16'h0002, 0, 0, 16'h0001, 12'h501, 2'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
